// File: rtl/crc24_stream_arbiter_pkg.sv
// CRC-24 constants, byte-update function and FSM state
// type shared by the stream arbiter and its CRC engine.
package crc24_pkg;

    localparam logic [23:0] CRC24_POLY = 24'h864CFB;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        APPEND
    } state_t;

    // MSB-first, unreflected byte update
    function automatic logic [23:0] step(
        input logic [23:0] crc,
        input logic [7:0]  b
    );
        logic [23:0] c;
        c = crc ^ {b, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            if (c[23]) c = {c[22:0], 1'b0} ^ CRC24_POLY;
            else       c = {c[22:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc24_stream_arbiter_if.sv
// Requester-side and link-side stream signals of the
// CRC-24 arbiter, bundled with arbiter/environment views.
interface crc24_stream_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [8*N_REQ-1:0] s_tdata;
    logic [N_REQ-1:0]   s_tvalid;
    logic [N_REQ-1:0]   s_tlast;
    logic [N_REQ-1:0]   s_tready;
    logic [7:0]         m_tdata;
    logic               m_tvalid;
    logic               m_tlast;
    logic [ID_W-1:0]    m_tid;
    logic               m_tready;
    logic               busy;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast,
        output m_tid, busy
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast,
        input  m_tid, busy
    );

endinterface

// File: rtl/crc24_stream_arbiter_engine.sv
// Registered CRC-24 accumulator: clear reloads the
// initial value, en folds one byte into the register.
module crc24_engine
    import crc24_pkg::*;
#(
    parameter logic [23:0] CRC_INIT = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [23:0] crc
);

    always_ff @(posedge clk) begin
        if (!reset_n)   crc <= CRC_INIT;
        else if (clear) crc <= CRC_INIT;
        else if (en)    crc <= step(crc, din);
    end

endmodule

// File: rtl/crc24_stream_arbiter.sv
// Round-robin packet arbiter in front of one shared CRC-24
// engine; appends the 3-byte CRC behind every packet.
module crc24_stream_arbiter
    import crc24_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          ID_W     = 2,
    parameter logic [23:0] CRC_INIT = 24'h000000
) (
    input logic                    clk,
    input logic                    reset_n,
    crc24_stream_arbiter_if.slave  bus
);

    state_t          state;
    logic [ID_W-1:0] g;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic [1:0]      cnt;
    logic [23:0]     crc;
    logic [7:0]      s_byte;
    logic            out_free;
    logic            any_req;
    logic            hs;
    logic            crc_clear;

    assign out_free  = bus.m_tready | ~bus.m_tvalid;
    assign any_req   = |bus.s_tvalid;
    assign s_byte    = bus.s_tdata[{g, 3'b000} +: 8];
    assign hs        = (state == PASS) && bus.s_tvalid[g] && out_free;
    assign crc_clear = (state == IDLE) && any_req;
    assign bus.busy  = (state != IDLE);

    assign bus.s_tready = (state == PASS && out_free)
                        ? (N_REQ'(1) << g) : '0;

    // Scan downward in distance so the nearest requester
    // above last_grant is the one left in pick.
    always_comb begin
        pick = last_grant;
        idx  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ID_W'((int'(last_grant) + i) % N_REQ);
            if (bus.s_tvalid[idx]) pick = idx;
        end
    end

    crc24_engine #(
        .CRC_INIT (CRC_INIT)
    ) u_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .en      (hs),
        .din     (s_byte),
        .crc     (crc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            g            <= '0;
            last_grant   <= ID_W'(N_REQ - 1);
            cnt          <= '0;
            bus.m_tdata  <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast  <= 1'b0;
            bus.m_tid    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (out_free) begin
                        bus.m_tvalid <= 1'b0;
                        bus.m_tlast  <= 1'b0;
                    end
                    if (any_req) begin
                        g     <= pick;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (hs) begin
                        bus.m_tdata  <= s_byte;
                        bus.m_tvalid <= 1'b1;
                        bus.m_tlast  <= 1'b0;
                        bus.m_tid    <= g;
                        if (bus.s_tlast[g]) begin
                            cnt   <= '0;
                            state <= APPEND;
                        end
                    end else if (out_free) begin
                        bus.m_tvalid <= 1'b0;
                        bus.m_tlast  <= 1'b0;
                    end
                end
                APPEND: begin
                    if (out_free) begin
                        case (cnt)
                            2'd0:    bus.m_tdata <= crc[23:16];
                            2'd1:    bus.m_tdata <= crc[15:8];
                            default: bus.m_tdata <= crc[7:0];
                        endcase
                        bus.m_tvalid <= 1'b1;
                        bus.m_tid    <= g;
                        bus.m_tlast  <= (cnt == 2'd2);
                        cnt          <= cnt + 2'd1;
                        if (cnt == 2'd2) begin
                            last_grant <= g;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc24_stream_arbiter.sv
// Directed bench for crc24_stream_arbiter: CRC vectors,
// round-robin order, throttling and mid-packet reset.
module tb_crc24_stream_arbiter;

    logic clk;
    logic reset_n;
    logic [3:0][7:0] dat;
    logic [3:0]      vld;
    logic [3:0]      lst;
    logic            mrdy;

    int errors = 0;
    int checks = 0;

    logic [11:0] q[$];
    logic [11:0] ref16[$];
    logic [11:0] prev_beat;
    logic        prev_stall = 1'b0;
    bit          stab_on = 1'b0;
    bit          rr_on = 1'b0;
    bit          busy_on = 1'b0;
    int          rr_viol = 0;
    int          busy_cycles = 0;

    crc24_stream_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

    assign bus.s_tdata  = dat;
    assign bus.s_tvalid = vld;
    assign bus.s_tlast  = lst;
    assign bus.m_tready = mrdy;

    crc24_stream_arbiter #(
        .N_REQ    (4),
        .ID_W     (2),
        .CRC_INIT (24'h000000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC (poly 0x864CFB, init 0)
    function automatic logic [23:0] crc_ref(input logic [7:0] b[$]);
        logic [23:0] c;
        logic        fb;
        c = '0;
        foreach (b[n]) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[23] ^ b[n][i];
                c  = {c[22:0], 1'b0};
                if (fb) c = c ^ 24'h864CFB;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.m_tvalid && mrdy)
            q.push_back({1'b0, bus.m_tid, bus.m_tlast, bus.m_tdata});
        if (stab_on && prev_stall)
            chk("stall_hold",
                {1'b0, bus.m_tid, bus.m_tlast, bus.m_tdata}, prev_beat);
        prev_stall = reset_n && bus.m_tvalid && !mrdy;
        prev_beat  = {1'b0, bus.m_tid, bus.m_tlast, bus.m_tdata};
        if (rr_on && !$onehot0(bus.s_tready)) rr_viol++;
        if (busy_on && bus.busy) busy_cycles++;
    end

    task automatic send_pkt(input int k, input logic [7:0] pkt[$]);
        int n;
        for (int i = 0; i < pkt.size(); i++) begin
            vld[k] = 1'b1;
            dat[k] = pkt[i];
            lst[k] = (i == pkt.size() - 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.s_tready[k] && n < 400);
            chk($sformatf("hs_timeout_req%0d", k), 32'(n < 400), 32'd1);
            @(posedge clk);
            #1;
        end
        vld[k] = 1'b0;
        lst[k] = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int k;
        k = 0;
        while (q.size() < n && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({tag, "_beats"}, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic check_pkt(input string tag, input int base,
                             input logic [7:0] pkt[$],
                             input logic [1:0] tid);
        logic [23:0] c;
        logic [11:0] e;
        int          len;
        c   = crc_ref(pkt);
        len = pkt.size();
        for (int i = 0; i < len + 3; i++) begin
            if (i < len)       e = {1'b0, tid, 1'b0, pkt[i]};
            else if (i == len) e = {1'b0, tid, 1'b0, c[23:16]};
            else if (i == len + 1) e = {1'b0, tid, 1'b0, c[15:8]};
            else               e = {1'b0, tid, 1'b1, c[7:0]};
            chk($sformatf("%s_beat%0d", tag, i), q[base + i], e);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [7:0] p16[$];
        int t;
        reset_n = 1'b0;
        dat = '0;
        vld = '0;
        lst = '0;
        mrdy = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(bus.m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
        chk("rst_m_tid", 32'(bus.m_tid), 32'd0);
        chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Hand-computed: CRC(01) = 864CFB
        q.delete();
        send_pkt(0, '{8'h01});
        wait_beats("req0_1b", 4);
        chk("req0_b0", q[0], {1'b0, 2'd0, 1'b0, 8'h01});
        chk("req0_b1", q[1], {1'b0, 2'd0, 1'b0, 8'h86});
        chk("req0_b2", q[2], {1'b0, 2'd0, 1'b0, 8'h4C});
        chk("req0_b3", q[3], {1'b0, 2'd0, 1'b1, 8'hFB});

        // CRC(00 01) = 864CFB, tid 2 throughout
        q.delete();
        send_pkt(2, '{8'h00, 8'h01});
        wait_beats("req2_2b", 5);
        chk("req2_b0", q[0], {1'b0, 2'd2, 1'b0, 8'h00});
        chk("req2_b1", q[1], {1'b0, 2'd2, 1'b0, 8'h01});
        chk("req2_b2", q[2], {1'b0, 2'd2, 1'b0, 8'h86});
        chk("req2_b3", q[3], {1'b0, 2'd2, 1'b0, 8'h4C});
        chk("req2_b4", q[4], {1'b0, 2'd2, 1'b1, 8'hFB});

        // CRC(02) = 8AD50D, then back to idle
        q.delete();
        send_pkt(1, '{8'h02});
        wait_beats("req1_1b", 4);
        chk("req1_b0", q[0], {1'b0, 2'd1, 1'b0, 8'h02});
        chk("req1_b1", q[1], {1'b0, 2'd1, 1'b0, 8'h8A});
        chk("req1_b2", q[2], {1'b0, 2'd1, 1'b0, 8'hD5});
        chk("req1_b3", q[3], {1'b0, 2'd1, 1'b1, 8'h0D});
        repeat (2) @(negedge clk);
        #1;
        chk("req1_idle_busy", 32'(bus.busy), 32'd0);
        chk("req1_idle_valid", 32'(bus.m_tvalid), 32'd0);

        // All four contending: order 0,1,2,3,0
        do_reset();
        rr_on = 1'b1;
        fork
            begin
                send_pkt(0, '{8'h10});
                send_pkt(0, '{8'h14});
            end
            send_pkt(1, '{8'h11});
            send_pkt(2, '{8'h12});
            send_pkt(3, '{8'h13});
        join
        wait_beats("rr", 20);
        rr_on = 1'b0;
        check_pkt("rr_p0", 0, '{8'h10}, 2'd0);
        check_pkt("rr_p1", 4, '{8'h11}, 2'd1);
        check_pkt("rr_p2", 8, '{8'h12}, 2'd2);
        check_pkt("rr_p3", 12, '{8'h13}, 2'd3);
        check_pkt("rr_p4", 16, '{8'h14}, 2'd0);
        chk("rr_ready_onehot", 32'(rr_viol), 32'd0);

        // 16-byte packet, unthrottled: L+3 busy cycles
        for (int i = 0; i < 16; i++) p16.push_back(8'(i * 37 + 5));
        q.delete();
        busy_cycles = 0;
        busy_on = 1'b1;
        send_pkt(0, p16);
        wait_beats("p16_free", 19);
        repeat (2) @(negedge clk);
        busy_on = 1'b0;
        chk("p16_busy_cycles", 32'(busy_cycles), 32'd19);
        check_pkt("p16_free", 0, p16, 2'd0);
        ref16 = q;

        // Same packet under random backpressure
        q.delete();
        stab_on = 1'b1;
        t = 0;
        fork
            send_pkt(0, p16);
            begin
                while (q.size() < 19 && t < 3000) begin
                    @(posedge clk);
                    #1;
                    mrdy = 1'($urandom_range(0, 1));
                    t++;
                end
                mrdy = 1'b1;
            end
        join
        wait_beats("p16_thr", 19);
        stab_on = 1'b0;
        for (int i = 0; i < 19; i++)
            chk($sformatf("p16_thr_beat%0d", i), q[i], ref16[i]);

        // Reset in APPEND with cnt==1 (first CRC byte showing)
        q.delete();
        send_pkt(2, '{8'h07});
        wait_beats("mid_rst", 2);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", 32'(bus.m_tvalid), 32'd0);
        chk("mid_rst_last", 32'(bus.m_tlast), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_tid", 32'(bus.m_tid), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        q.delete();

        // Tie after reset: req0 wins, then req3 with CRC re-initialised
        fork
            send_pkt(0, '{8'h02});
            send_pkt(3, '{8'h01});
        join
        wait_beats("post_rst", 8);
        chk("post_b0", q[0], {1'b0, 2'd0, 1'b0, 8'h02});
        chk("post_b1", q[1], {1'b0, 2'd0, 1'b0, 8'h8A});
        chk("post_b2", q[2], {1'b0, 2'd0, 1'b0, 8'hD5});
        chk("post_b3", q[3], {1'b0, 2'd0, 1'b1, 8'h0D});
        chk("post_b4", q[4], {1'b0, 2'd3, 1'b0, 8'h01});
        chk("post_b5", q[5], {1'b0, 2'd3, 1'b0, 8'h86});
        chk("post_b6", q[6], {1'b0, 2'd3, 1'b0, 8'h4C});
        chk("post_b7", q[7], {1'b0, 2'd3, 1'b1, 8'hFB});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc24_stream_arbiter.md
Name: crc24_stream_arbiter

Overview:
Round-robin packet arbiter that shares one CRC-24 engine between N byte-wide AXI-Stream requesters. It grants one requester per packet and forwards that packet's bytes to a single AXI-Stream master. Behind each packet it appends the 3-byte CRC-24 of the packet, MSB first, and tags every output byte with the requester index. It sits between the per-channel byte sources and the shared link/serializer.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, width of m_tid; must satisfy 2**ID_W >= N_REQ
CRC_INIT, 24'h000000, CRC register value loaded at the start of every packet

Ports:
clk  input  1  clock
reset_n  input  1  synchronous, active-low reset
s_tdata  input  8*N_REQ  requester bytes; requester k occupies bits [8k+7:8k]
s_tvalid  input  N_REQ  per-requester valid
s_tlast  input  N_REQ  per-requester last byte of packet
s_tready  output  N_REQ  per-requester ready
m_tdata  output  8  output byte
m_tvalid  output  1  output valid
m_tlast  output  1  asserted only on the final CRC byte
m_tid  output  ID_W  index of the requester that owns the current output byte
m_tready  input  1  downstream ready
busy  output  1  high in PASS and APPEND states

Behaviour:
- Clock and reset: clk; reset_n is synchronous and active-low.
- CRC-24 definition:
  - poly 0x864CFB (implicit x^24), MSB-first, no reflection, no final XOR.
  - Byte update: crc = step(crc, b), i.e. 8 shift/XOR iterations with b XORed into crc[23:16].
  - Only packet data bytes are hashed.
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0, s_tready=0, busy=0; state=IDLE; rr pointer chosen so requester 0 has top priority; crc=CRC_INIT.
- Output register: out_free = m_tready | ~m_tvalid. While m_tvalid && !m_tready, m_tdata, m_tlast and m_tid are held stable.
- State IDLE:
  - s_tready=0 on all ports.
  - If any s_tvalid is set, grant the first requester found searching upward (modulo N_REQ) from last_grant+1.
  - Latch g, load crc=CRC_INIT, go to PASS. Arbitration costs exactly 1 cycle.
- State PASS:
  - s_tready[g] = out_free; all other ready bits are 0.
  - On an s handshake: m_tdata<=byte, m_tvalid<=1, m_tlast<=0, m_tid<=g, crc<=step(crc,byte).
  - If s_tlast[g] is set on that beat: cnt<=0, go to APPEND.
  - If out_free and no handshake: m_tvalid<=0.
- State APPEND:
  - When out_free: m_tdata <= crc[23:16], then crc[15:8], then crc[7:0] for cnt 0, 1, 2; m_tvalid<=1, m_tid<=g.
  - m_tlast<=1 only when cnt==2; on that beat last_grant<=g and go to IDLE.
  - s_tready is all 0 in this state.
- Latency and throughput:
  - Input byte to m_tvalid: 1 cycle.
  - A packet of L bytes occupies L+4 cycles with no backpressure.
- Boundaries:
  - A requester is never pre-empted mid-packet, even if its s_tvalid drops; the block waits in PASS.
  - A single-byte packet (tlast on the first beat) is legal.
  - A requester that deasserts s_tvalid before its grant simply loses its turn.
  - After a packet from requester k, the winner is the next valid requester in k+1..N_REQ-1, then 0..k; requester k itself only if it is the sole one valid.
  - N_REQ=1 degenerates to a CRC appender.
  - Reset asserted mid-packet: all outputs return to reset values the next cycle; any partial packet is discarded and never completed.

Decomposition:
- Package crc24_pkg holds:
  - CRC24_POLY = 24'h864CFB
  - the step() byte-update function
  - state enum {IDLE, PASS, APPEND}
- One sub-module: crc24_engine (clk, reset_n, clear, en, din[7:0], crc[23:0]). It registers the CRC and is instantiated once. Arbiter, FSM and output register remain in the top module.

Test Plan:
- Req0 sends 1-byte packet 0x01 with tlast -> m: 0x01, 0x86, 0x4C, 0xFB; m_tlast only on 0xFB; m_tid=0.
- Req2 sends {0x00, 0x01} -> m: 0x00, 0x01, 0x86, 0x4C, 0xFB; m_tid=2 on all 5 beats.
- Req1 sends 0x02 -> m: 0x02, 0x8A, 0xD5, 0x0D, then back to IDLE.
- All 4 requesters continuously valid with 1-byte packets -> m_tid order 0, 1, 2, 3, 0; s_tready never high on a non-granted port.
- Random m_tready throttling on a 16-byte packet -> output byte/CRC sequence identical to the unthrottled run; data stable while stalled.
- reset_n pulled low during APPEND cnt==1 -> m_tvalid=0 next cycle; the following req3 packet 0x01 yields 0x01, 0x86, 0x4C, 0xFB (CRC re-initialised; rr pointer reset, so req0 would win a tie).
